// File: rtl/mem_access_ctrl_pkg.sv
// Shared op codes, FSM state encoding and op-decode helpers for the MEM-stage
// load/store sequencer.
package mem_access_ctrl_pkg;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        MEM_ST_IDLE  = 2'd0,
        MEM_ST_REQ   = 2'd1,
        MEM_ST_WAIT  = 2'd2,
        MEM_ST_DRAIN = 2'd3
    } mem_state_e;

    function automatic logic is_load_op(input logic [7:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP);
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    // Halfwords need addr[0] clear, words need addr[1:0] clear; bytes never fault.
    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] lo);
        case (op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: is_misaligned = lo[0];
            EXE_LW_OP, EXE_SW_OP:             is_misaligned = (lo != 2'b00);
            default:                          is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-bus request/response signals between the MEM-stage sequencer (master)
// and the memory system (slave).
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [3:0]        data_wen;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        output data_req, data_wr, data_wen, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_wen, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_access_ctrl_store_lane_gen.sv
// Combinational big-endian byte-strobe and lane-replicated write data generator
// for SB/SH/SW; lane 3 (wen[3]) carries bits [31:24] at byte offset 00.
module store_lane_gen
    import mem_access_ctrl_pkg::*;
(
    input  logic [7:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    output logic [3:0]  wen,
    output logic [31:0] wdata
);
    logic [31:0] byte_rep;
    logic [31:0] half_rep;

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_rep
        assign byte_rep[gi*8 +: 8] = store_data[7:0];
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_half_rep
        assign half_rep[gi*16 +: 16] = store_data[15:0];
    end

    always_comb begin
        wen   = 4'b0000;
        wdata = 32'h0;
        case (op)
            EXE_SW_OP: begin
                wen   = 4'b1111;
                wdata = store_data;
            end
            EXE_SH_OP: begin
                wen   = addr_lo[1] ? 4'b0011 : 4'b1100;
                wdata = half_rep;
            end
            EXE_SB_OP: begin
                wen   = 4'b1000 >> addr_lo;
                wdata = byte_rep;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: one bus transaction per memory op, pipeline
// stall until completion. Optional address-error detection under MEM_ADDR_EXC_EN.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [7:0]        alu_control,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic              flush,
    mem_access_ctrl_if.master bus,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] rd_word,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_op,
    output logic              adel,
    output logic              ades,
    output logic [ADDR_W-1:0] bad_vaddr
);
    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wen_q, wen_d;
    logic              wr_q, wr_d;
    logic [7:0]        op_q, op_d;
    logic [DATA_W-1:0] rd_word_q, rd_word_d;
    logic              done_q, done_d;
    logic              adel_q, adel_d;
    logic              ades_q, ades_d;
    logic [ADDR_W-1:0] bad_vaddr_q, bad_vaddr_d;

    logic [3:0]        lane_wen;
    logic [DATA_W-1:0] lane_wdata;
    logic              is_mem;
    logic              addr_exc;
    logic              launch;

    store_lane_gen u_store_lane_gen (
        .op         (alu_control),
        .addr_lo    (addr[1:0]),
        .store_data (store_data),
        .wen        (lane_wen),
        .wdata      (lane_wdata)
    );

    always_comb begin
        is_mem = is_load_op(alu_control) || is_store_op(alu_control);
`ifdef MEM_ADDR_EXC_EN
        addr_exc = req_valid && is_mem && is_misaligned(alu_control, addr[1:0]);
`else
        addr_exc = 1'b0;
`endif
        // done_q blocks re-launching the instruction still held in EX/MEM.
        launch = !rst && (state_q == MEM_ST_IDLE) && req_valid && is_mem &&
                 !flush && !done_q && !addr_exc;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wen_d       = wen_q;
        wr_d        = wr_q;
        op_d        = op_q;
        rd_word_d   = rd_word_q;
        done_d      = 1'b0;
        adel_d      = 1'b0;
        ades_d      = 1'b0;
        bad_vaddr_d = bad_vaddr_q;

        unique case (state_q)
            MEM_ST_IDLE: begin
                if (launch) begin
                    state_d = MEM_ST_REQ;
                    addr_d  = addr;
                    wdata_d = lane_wdata;
                    wen_d   = lane_wen;
                    wr_d    = is_store_op(alu_control);
                    op_d    = alu_control;
                end
            end
            MEM_ST_REQ: begin
                if (bus.data_addr_ok) begin
                    if (bus.data_data_ok) begin
                        state_d = MEM_ST_IDLE;
                        if (!flush) begin
                            done_d = 1'b1;
                            if (!wr_q) rd_word_d = bus.data_rdata;
                        end
                    end else begin
                        state_d = flush ? MEM_ST_DRAIN : MEM_ST_WAIT;
                    end
                end else if (flush) begin
                    state_d = MEM_ST_IDLE;
                end
            end
            MEM_ST_WAIT: begin
                if (bus.data_data_ok) begin
                    state_d = MEM_ST_IDLE;
                    if (!flush) begin
                        done_d = 1'b1;
                        if (!wr_q) rd_word_d = bus.data_rdata;
                    end
                end else if (flush) begin
                    state_d = MEM_ST_DRAIN;
                end
            end
            MEM_ST_DRAIN: begin
                if (bus.data_data_ok) state_d = MEM_ST_IDLE;
            end
        endcase

`ifdef MEM_ADDR_EXC_EN
        if (!rst && (state_q == MEM_ST_IDLE) && addr_exc && !flush && !done_q) begin
            adel_d      = is_load_op(alu_control);
            ades_d      = is_store_op(alu_control);
            bad_vaddr_d = addr;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MEM_ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wen_q       <= '0;
            wr_q        <= 1'b0;
            op_q        <= '0;
            rd_word_q   <= '0;
            done_q      <= 1'b0;
            adel_q      <= 1'b0;
            ades_q      <= 1'b0;
            bad_vaddr_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wen_q       <= wen_d;
            wr_q        <= wr_d;
            op_q        <= op_d;
            rd_word_q   <= rd_word_d;
            done_q      <= done_d;
            adel_q      <= adel_d;
            ades_q      <= ades_d;
            bad_vaddr_q <= bad_vaddr_d;
        end
    end

    assign bus.data_req   = (state_q == MEM_ST_REQ);
    assign bus.data_wr    = wr_q;
    assign bus.data_wen   = wen_q;
    assign bus.data_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.data_wdata = wdata_q;

    assign stall     = launch || (state_q != MEM_ST_IDLE);
    assign done      = done_q;
    assign rd_word   = rd_word_q;
    assign rd_addr   = addr_q;
    assign rd_op     = op_q;
    assign adel      = adel_q;
    assign ades      = ades_q;
    assign bad_vaddr = bad_vaddr_q;

endmodule
